// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for mem_port_arbiter: FSM encodings and kseg0/kseg1 segment remap.
package mem_port_arbiter_pkg;

   localparam logic [0:0] ARB_IDLE = 1'b0;
   localparam logic [0:0] ARB_BUSY = 1'b1;

   localparam logic [2:0] SEG_KSEG0 = 3'b100;
   localparam logic [2:0] SEG_KSEG1 = 3'b101;
   localparam logic [2:0] SEG_PHYS  = 3'b000;

   // Unmapped kernel segments alias the low physical window.
   function automatic logic [2:0] remap_seg(input logic [2:0] seg);
      logic [2:0] res;
      case (seg)
         SEG_KSEG0, SEG_KSEG1: res = SEG_PHYS;
         default:              res = seg;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational picker: first set bit of req at or after ptr, wrapping past N_CH-1 to 0.
module arb_pick #(
   parameter int N_CH  = 2,
   parameter int IDX_W = 1
) (
   input  logic [N_CH-1:0]  req,
   input  logic [IDX_W-1:0] ptr,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_vld
);

   int cand_s;

   // Scan channels in rotated order starting at ptr.
   always_comb begin
      gnt_idx = '0;
      gnt_vld = 1'b0;
      cand_s  = 0;
      for (int k = 0; k < N_CH; k++) begin
         cand_s = int'(ptr) + k;
         if (cand_s >= N_CH) begin
            cand_s = cand_s - N_CH;
         end else begin
            cand_s = cand_s;
         end
         if (!gnt_vld && req[cand_s]) begin
            gnt_vld = 1'b1;
            gnt_idx = IDX_W'(cand_s);
         end else begin
            gnt_vld = gnt_vld;
         end
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// N-channel memory port arbiter with transaction-long grant and flush forwarding.
// Define MEM_ARB_RR_EN for round-robin selection; otherwise lowest index wins.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int N_CH   = 2,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int REMAP  = 1
) (
   input  logic                       aclk,
   input  logic                       aresetn,
   input  logic [N_CH-1:0]            ch_req,
   input  logic [N_CH-1:0]            ch_write,
   input  logic [2*N_CH-1:0]          ch_size,
   input  logic [(DATA_W/8)*N_CH-1:0] ch_sel,
   input  logic [ADDR_W*N_CH-1:0]     ch_addr,
   input  logic [DATA_W*N_CH-1:0]     ch_st_data,
   input  logic [N_CH-1:0]            ch_flush,
   output logic [N_CH-1:0]            ch_ready,
   output logic [DATA_W-1:0]          ch_rdata,
   output logic [ADDR_W-1:0]          mem_a,
   output logic                       mem_access,
   output logic                       mem_write,
   output logic [1:0]                 mem_size,
   output logic [DATA_W/8-1:0]        mem_sel,
   output logic [DATA_W-1:0]          mem_st_data,
   output logic                       mem_flush,
   input  logic                       mem_ready,
   input  logic [DATA_W-1:0]          mem_data
);

   localparam int IDX_W = $clog2(N_CH);
   localparam int SEL_W = DATA_W / 8;

   logic [0:0]       state_q, state_d;
   logic [IDX_W-1:0] grant_q, grant_d;
   logic [IDX_W-1:0] ptr_s, pick_idx_s;
   logic             pick_vld_s;
   logic [N_CH-1:0]  elig_s;
   logic [ADDR_W-1:0] addr_g_s;
   logic             busy_s, g_req_s, g_flush_s, done_s;

   assign elig_s = ch_req & ~ch_flush;

`ifdef MEM_ARB_RR_EN
   logic [IDX_W-1:0] ptr_q, ptr_d;
   assign ptr_s = ptr_q;

   // Pointer moves past a channel only when its transaction completes normally.
   always_comb begin
      if (done_s) begin
         ptr_d = (grant_q == IDX_W'(N_CH - 1)) ? '0 : grant_q + IDX_W'(1);
      end else begin
         ptr_d = ptr_q;
      end
   end

   // Round-robin pointer register.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`else
   assign ptr_s = '0;
`endif

   arb_pick #(
      .N_CH  (N_CH),
      .IDX_W (IDX_W)
   ) u_pick (
      .req     (elig_s),
      .ptr     (ptr_s),
      .gnt_idx (pick_idx_s),
      .gnt_vld (pick_vld_s)
   );

   // Reset gates the handshake outputs so a mid-transaction reset is silent.
   assign busy_s    = (state_q == ARB_BUSY) && aresetn;
   assign g_req_s   = ch_req[grant_q];
   assign g_flush_s = ch_flush[grant_q];
   assign done_s    = busy_s && mem_ready && !g_flush_s;

   assign addr_g_s    = ch_addr[int'(grant_q)*ADDR_W +: ADDR_W];
   assign mem_a       = (REMAP != 0) ? {remap_seg(addr_g_s[ADDR_W-1 -: 3]), addr_g_s[ADDR_W-4:0]}
                                     : addr_g_s;
   assign mem_write   = ch_write[grant_q];
   assign mem_size    = ch_size[int'(grant_q)*2 +: 2];
   assign mem_sel     = ch_sel[int'(grant_q)*SEL_W +: SEL_W];
   assign mem_st_data = ch_st_data[int'(grant_q)*DATA_W +: DATA_W];
   assign mem_access  = busy_s && g_req_s && !g_flush_s;
   assign mem_flush   = busy_s && g_flush_s;
   assign ch_ready    = done_s ? ({{(N_CH-1){1'b0}}, 1'b1} << grant_q) : '0;
   assign ch_rdata    = mem_data;

   // Next-state: flush and completion both end the transaction.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      case (state_q)
         ARB_IDLE: begin
            if (pick_vld_s) begin
               state_d = ARB_BUSY;
               grant_d = pick_idx_s;
            end else begin
               state_d = ARB_IDLE;
            end
         end
         ARB_BUSY: begin
            if (g_flush_s || mem_ready) begin
               state_d = ARB_IDLE;
            end else begin
               state_d = ARB_BUSY;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   // State and grant registers.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q <= ARB_IDLE;
         grant_q <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (N_CH = 4): directed plan steps plus random traffic.
module tb_mem_port_arbiter;

   localparam int N = 4;

   logic           aclk = 1'b0;
   logic           aresetn = 1'b0;
   logic [N-1:0]   ch_req, ch_write, ch_flush, ch_ready;
   logic [2*N-1:0] ch_size;
   logic [4*N-1:0] ch_sel;
   logic [32*N-1:0] ch_addr, ch_st_data;
   logic [31:0]    ch_rdata, mem_a, mem_st_data, mem_data;
   logic           mem_access, mem_write, mem_flush, mem_ready;
   logic [1:0]     mem_size;
   logic [3:0]     mem_sel;

   mem_port_arbiter #(.N_CH(N), .ADDR_W(32), .DATA_W(32), .REMAP(1)) dut (
      .aclk(aclk), .aresetn(aresetn), .ch_req(ch_req), .ch_write(ch_write),
      .ch_size(ch_size), .ch_sel(ch_sel), .ch_addr(ch_addr), .ch_st_data(ch_st_data),
      .ch_flush(ch_flush), .ch_ready(ch_ready), .ch_rdata(ch_rdata), .mem_a(mem_a),
      .mem_access(mem_access), .mem_write(mem_write), .mem_size(mem_size),
      .mem_sel(mem_sel), .mem_st_data(mem_st_data), .mem_flush(mem_flush),
      .mem_ready(mem_ready), .mem_data(mem_data)
   );

   always #5 aclk = ~aclk;

   bit          rq[N], fl[N], wr[N];
   logic [1:0]  sz[N];
   logic [3:0]  sl[N];
   logic [31:0] ad[N], sd[N];

   int cmps = 0;
   int errs = 0;
   bit m_busy;
   int m_grant, m_ptr;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      cmps++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] phys(input logic [31:0] a);
      if (a >= 32'h8000_0000 && a < 32'hA000_0000) return a - 32'h8000_0000;
      if (a >= 32'hA000_0000 && a < 32'hC000_0000) return a - 32'hA000_0000;
      return a;
   endfunction

   function automatic int pick(input bit [N-1:0] e, input int p);
      int start;
`ifdef MEM_ARB_RR_EN
      start = p;
`else
      start = 0;
`endif
      for (int k = 0; k < N; k++) begin
         if (e[(start + k) % N]) return (start + k) % N;
      end
      return -1;
   endfunction

   task automatic sample();
      int  g;
      bit  eb;
      for (int c = 0; c < N; c++) begin
         ch_req[c] = rq[c]; ch_flush[c] = fl[c]; ch_write[c] = wr[c];
         ch_size[c*2 +: 2] = sz[c]; ch_sel[c*4 +: 4] = sl[c];
         ch_addr[c*32 +: 32] = ad[c]; ch_st_data[c*32 +: 32] = sd[c];
      end
      #1;
      g  = m_grant;
      eb = m_busy && (aresetn === 1'b1);
      chk("mem_access", mem_access, eb && rq[g] && !fl[g]);
      chk("mem_flush", mem_flush, eb && fl[g]);
      chk("ch_ready", ch_ready, (eb && mem_ready && !fl[g]) ? (64'd1 << g) : 64'd0);
      chk("mem_a", mem_a, phys(ad[g]));
      chk("mem_write", mem_write, wr[g]);
      chk("mem_size", mem_size, sz[g]);
      chk("mem_sel", mem_sel, sl[g]);
      chk("mem_st_data", mem_st_data, sd[g]);
      chk("ch_rdata", ch_rdata, mem_data);
   endtask

   task automatic adv();
      bit [N-1:0] e;
      int w;
      if (!aresetn) begin
         m_busy = 1'b0; m_grant = 0; m_ptr = 0;
      end else if (!m_busy) begin
         for (int c = 0; c < N; c++) e[c] = rq[c] && !fl[c];
         w = pick(e, m_ptr);
         if (w >= 0) begin
            m_busy = 1'b1; m_grant = w;
         end
      end else if (fl[m_grant]) begin
         m_busy = 1'b0;
      end else if (mem_ready) begin
         m_busy = 1'b0;
         m_ptr  = (m_grant + 1) % N;
      end
      @(negedge aclk);
   endtask

   task automatic tick();
      sample();
      adv();
   endtask

   initial begin
      logic [31:0] exp_rr;
      for (int c = 0; c < N; c++) begin
         rq[c] = 1'b1; fl[c] = 1'b0; wr[c] = 1'b0; sz[c] = 2'd2;
         sl[c] = 4'hF; ad[c] = 32'h0000_1000 * c; sd[c] = 32'h0;
      end
      mem_ready = 1'b0;
      mem_data  = 32'h0;
      aresetn   = 1'b0;
      m_busy = 1'b0; m_grant = 0; m_ptr = 0;
      @(posedge aclk);
      @(negedge aclk);

      // reset held with every channel requesting
      for (int i = 0; i < 3; i++) tick();
      aresetn = 1'b1;
      tick();
      mem_ready = 1'b1;
      sample();
      chk("rst_rise", mem_access, 1'b1);
      adv();
      mem_ready = 1'b0;
      for (int c = 0; c < N; c++) rq[c] = 1'b0;
      tick();

      // single uncached load through kseg1
      rq[1] = 1'b1; ad[1] = 32'hBFC0_0000;
      tick();
      for (int i = 0; i < 3; i++) tick();
      mem_ready = 1'b1; mem_data = 32'h1234_5678;
      sample();
      chk("single_a", mem_a, 32'h1FC0_0000);
      chk("single_ready", ch_ready, 4'b0010);
      chk("single_rdata", ch_rdata, 32'h1234_5678);
      adv();
      mem_ready = 1'b0; rq[1] = 1'b0;

      // contention between ch0 and ch1 with one-cycle accesses
      rq[0] = 1'b1; rq[1] = 1'b1; mem_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         sample();
         if (i % 2 == 1) begin
`ifdef MEM_ARB_RR_EN
            exp_rr = (i % 4 == 1) ? 32'd1 : 32'd2;
`else
            exp_rr = 32'd1;
`endif
            chk("contention", ch_ready, exp_rr);
         end
         adv();
      end

      // flush of the granted channel coinciding with mem_ready
      mem_ready = 1'b0;
      tick();
      fl[0] = 1'b1; mem_ready = 1'b1;
      sample();
      chk("flush_mem_flush", mem_flush, 1'b1);
      chk("flush_no_ready", ch_ready, 4'b0000);
      adv();
      fl[0] = 1'b0; rq[0] = 1'b0; mem_ready = 1'b0;
      tick();
      mem_ready = 1'b1;
      sample();
      chk("flush_next_grant", ch_ready, 4'b0010);
      adv();
      mem_ready = 1'b0; rq[1] = 1'b0;

      // pointer wrap: finish on ch2, then ch1 and ch2 compete
      rq[2] = 1'b1;
      tick();
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0; rq[1] = 1'b1;
      tick();
      mem_ready = 1'b1;
      sample();
      chk("wrap_grant", ch_ready, 4'b0010);
      adv();
      mem_ready = 1'b0; rq[1] = 1'b0; rq[2] = 1'b0;
      tick();

      // store passthrough
      rq[0] = 1'b1; wr[0] = 1'b1; sd[0] = 32'hDEAD_BEEF; sl[0] = 4'b0011; sz[0] = 2'd1;
      tick();
      sample();
      chk("store_write", mem_write, 1'b1);
      chk("store_sel", mem_sel, 4'b0011);
      chk("store_size", mem_size, 2'd1);
      chk("store_data", mem_st_data, 32'hDEAD_BEEF);
      adv();
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0; rq[0] = 1'b0; wr[0] = 1'b0;

      // random traffic against the reference model
      for (int i = 0; i < 400; i++) begin
         for (int c = 0; c < N; c++) begin
            logic [2:0] top;
            case ($urandom_range(2))
               0:       top = 3'b100;
               1:       top = 3'b101;
               default: top = 3'($urandom_range(7));
            endcase
            ad[c] = {top, 29'($urandom)};
            sd[c] = $urandom;
            wr[c] = 1'($urandom_range(1));
            sz[c] = 2'($urandom_range(3));
            sl[c] = 4'($urandom_range(15));
            rq[c] = 1'($urandom_range(1));
            fl[c] = ($urandom_range(7) == 0);
         end
         if (m_busy && !fl[m_grant]) rq[m_grant] = 1'b1;
         mem_ready = ($urandom_range(2) == 0);
         mem_data  = $urandom;
         aresetn   = ($urandom_range(63) != 0);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
      $finish;
   end

endmodule
